// File: rtl/tlb_assoc_if.sv
// Bundle of the MMU lookup port and the CP0 management ports of tlb_assoc.
// master = pipeline/CP0 side, slave = the TLB itself.
interface tlb_assoc_if #(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8
);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int DATA_W = 64 + ASID_W;

  logic              lk_req;
  logic [31:0]       lk_vaddr;
  logic              lk_write;
  logic [ASID_W-1:0] lk_asid;
  logic              lk_valid;
  logic [31:0]       lk_paddr;
  logic              lk_refill;
  logic              lk_invalid;
  logic              lk_modified;

  logic              wr_en;
  logic              wr_random;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              wired_we;
  logic [IDX_W-1:0]  wired_data;
  logic [IDX_W-1:0]  random_o;

  logic              probe_req;
  logic [18:0]       probe_vpn2;
  logic [ASID_W-1:0] probe_asid;
  logic              probe_done;
  logic              probe_hit;
  logic [IDX_W-1:0]  probe_index;

  logic              rd_req;
  logic [IDX_W-1:0]  rd_index;
  logic [DATA_W-1:0] rd_data;

  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;

  modport master (
    output lk_req, lk_vaddr, lk_write, lk_asid,
    output wr_en, wr_random, wr_index, wr_data, wired_we, wired_data,
    output probe_req, probe_vpn2, probe_asid,
    output rd_req, rd_index,
    input  lk_valid, lk_paddr, lk_refill, lk_invalid, lk_modified,
    input  random_o, probe_done, probe_hit, probe_index, rd_data,
    input  stat_hits, stat_misses
  );

  modport slave (
    input  lk_req, lk_vaddr, lk_write, lk_asid,
    input  wr_en, wr_random, wr_index, wr_data, wired_we, wired_data,
    input  probe_req, probe_vpn2, probe_asid,
    input  rd_req, rd_index,
    output lk_valid, lk_paddr, lk_refill, lk_invalid, lk_modified,
    output random_o, probe_done, probe_hit, probe_index, rd_data,
    output stat_hits, stat_misses
  );
endinterface

// File: rtl/tlb_assoc.sv
// Fully-associative MIPS-style TLB: ASID/global match, even/odd page pairs, Wired/Random pointer.
// Define TLB_STATS_EN to build the saturating hit/refill counters; otherwise stat outputs are tied to 0.
module tlb_assoc #(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8
) (
  input logic         clk,
  input logic         rst,
  tlb_assoc_if.slave  bus
);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int DATA_W = 64 + ASID_W;
  localparam int VPN_LO = 45 + ASID_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(ENTRIES - 1);

  logic [DATA_W-1:0] entries [ENTRIES];

  function automatic logic ent_match(input logic [DATA_W-1:0] e,
                                     input logic [18:0]       vpn2,
                                     input logic [ASID_W-1:0] asid);
    return (e[DATA_W-1:VPN_LO] == vpn2) && (e[44] || (e[VPN_LO-1:45] == asid));
  endfunction

  // lowest matching index wins: scan downward so the last assignment is the lowest
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             pb_hit;
  logic [IDX_W-1:0] pb_idx;

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    pb_hit = 1'b0;
    pb_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_match(entries[i], bus.lk_vaddr[31:13], bus.lk_asid)) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (ent_match(entries[i], bus.probe_vpn2, bus.probe_asid)) begin
        pb_hit = 1'b1;
        pb_idx = IDX_W'(i);
      end
    end
  end

  logic [DATA_W-1:0] lk_ent;
  logic              lk_unmapped;
  logic              lk_odd;
  logic              pg_v;
  logic              pg_d;
  logic [19:0]       pg_pfn;

  assign lk_ent      = entries[lk_idx];
  assign lk_unmapped = (bus.lk_vaddr[31:30] == 2'b10);
  assign lk_odd      = bus.lk_vaddr[12];
  assign pg_v        = lk_odd ? lk_ent[22] : lk_ent[0];
  assign pg_d        = lk_odd ? lk_ent[23] : lk_ent[1];
  assign pg_pfn      = lk_odd ? lk_ent[43:24] : lk_ent[21:2];

  logic [31:0] paddr_d;
  logic        refill_d;
  logic        invalid_d;
  logic        modified_d;

  always_comb begin
    paddr_d    = '0;
    refill_d   = 1'b0;
    invalid_d  = 1'b0;
    modified_d = 1'b0;
    if (lk_unmapped)
      paddr_d = {3'b000, bus.lk_vaddr[28:0]};
    else if (!lk_hit)
      refill_d = 1'b1;
    else if (!pg_v)
      invalid_d = 1'b1;
    else if (bus.lk_write && !pg_d)
      modified_d = 1'b1;
    else
      paddr_d = {pg_pfn, bus.lk_vaddr[11:0]};
  end

  logic        lk_valid_q;
  logic [31:0] lk_paddr_q;
  logic        lk_refill_q;
  logic        lk_invalid_q;
  logic        lk_modified_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_valid_q    <= 1'b0;
      lk_paddr_q    <= '0;
      lk_refill_q   <= 1'b0;
      lk_invalid_q  <= 1'b0;
      lk_modified_q <= 1'b0;
    end else begin
      lk_valid_q <= bus.lk_req;
      if (bus.lk_req) begin
        lk_paddr_q    <= paddr_d;
        lk_refill_q   <= refill_d;
        lk_invalid_q  <= invalid_d;
        lk_modified_q <= modified_d;
      end
    end
  end

  logic [IDX_W-1:0] wired_q;
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] wr_addr;

  assign wr_addr = bus.wr_random ? random_q : bus.wr_index;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wired_q  <= '0;
      random_q <= IDX_MAX;
    end else if (bus.wired_we) begin
      wired_q  <= bus.wired_data;
      random_q <= IDX_MAX;
    end else if ((wired_q >= IDX_MAX) || (random_q == wired_q)) begin
      random_q <= IDX_MAX;
    end else begin
      random_q <= random_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++)
        entries[i] <= '0;
    end else if (bus.wr_en) begin
      entries[wr_addr] <= bus.wr_data;
    end
  end

  logic             pb_done_q;
  logic             pb_hit_q;
  logic [IDX_W-1:0] pb_idx_q;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_done_q <= 1'b0;
      pb_hit_q  <= 1'b0;
      pb_idx_q  <= '0;
      rd_data_q <= '0;
    end else begin
      pb_done_q <= bus.probe_req;
      if (bus.probe_req) begin
        pb_hit_q <= pb_hit;
        pb_idx_q <= pb_idx;
      end
      if (bus.rd_req)
        rd_data_q <= entries[bus.rd_index];
    end
  end

`ifdef TLB_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (bus.lk_req && !lk_unmapped) begin
      if (lk_hit && (hits_q != 32'hFFFF_FFFF))
        hits_q <= hits_q + 32'd1;
      if (!lk_hit && (misses_q != 32'hFFFF_FFFF))
        misses_q <= misses_q + 32'd1;
    end
  end

  assign bus.stat_hits   = hits_q;
  assign bus.stat_misses = misses_q;
`else
  assign bus.stat_hits   = '0;
  assign bus.stat_misses = '0;
`endif

  assign bus.lk_valid    = lk_valid_q;
  assign bus.lk_paddr    = lk_paddr_q;
  assign bus.lk_refill   = lk_refill_q;
  assign bus.lk_invalid  = lk_invalid_q;
  assign bus.lk_modified = lk_modified_q;
  assign bus.random_o    = random_q;
  assign bus.probe_done  = pb_done_q;
  assign bus.probe_hit   = pb_hit_q;
  assign bus.probe_index = pb_idx_q;
  assign bus.rd_data     = rd_data_q;
endmodule
